bitstream_buffer: RTL
=====================

# bitstream_buffer

Upstream feeder for the slice-header and fixed-length field decoders. Accepts 16-bit NAL payload words from the NAL memory interface, holds them in a bit-granular shift buffer, and presents a 16-bit window whose MSB is always the next unread bit. Downstream parsers read `BitStream_buffer_output` combinationally, report how many bits they used each cycle, and the buffer advances and refills.

## Interface

Parameters:
- `BUF_BITS`, default 48: buffer capacity in bits. Must be a multiple of 16 and at least 32.

Ports:
- `clk`  in  1  sole clock, rising edge.
- `reset_n`  in  1  asynchronous, active-low reset.
- `flush`  in  1  synchronous clear at the start of a new NAL unit.
- `word_in`  in  16  next payload word, MSB first in the stream.
- `word_valid`  in  1  `word_in` is valid.
- `word_ready`  out  1  buffer accepts a word this cycle.
- `consume_len`  in  5  bits consumed this cycle, 0..16.
- `byte_align`  in  1  consume up to the next byte boundary.
- `BitStream_buffer_output`  out  16  window; bit 15 is the next unread bit.
- `window_valid`  out  1  at least 16 valid bits are buffered.
- `bits_total`  out  24  bits consumed since the last flush or reset; wraps modulo 2^24.
- `consume_err`  out  1  sticky illegal-consume flag.

## Operation

- State: `buf[BUF_BITS-1:0]` (MSB-aligned), `fill_cnt` (0..`BUF_BITS`), `bits_total`, `consume_err`. Bits below the `fill_cnt` valid bits are always 0.
- Effective consume `c`:
  - When `byte_align`=1, `c` = (8 − `bits_total[2:0]`) mod 8 and `consume_len` is ignored.
  - Otherwise `c` = `consume_len`.
- Legality:
  - A consume is accepted iff `c` ≤ 16 and `c` ≤ `fill_cnt`.
  - An illegal consume sets `consume_err`, leaves `buf`, `fill_cnt` and `bits_total` unchanged, and is discarded. A word push in the same cycle still proceeds.
- Push:
  - `word_ready` = (`fill_cnt` ≤ `BUF_BITS` − 16) && !`flush`. It is combinational from registered `fill_cnt`; there is no path from `consume_len`.
  - A push happens when `word_valid` && `word_ready`.
- Update on an accepted consume plus an optional push:
  - `buf` ← (`buf` << c) | (`word_in` placed at bit position `BUF_BITS`−16−(`fill_cnt`−c) from LSB side, MSB-aligned after the valid bits).
  - `fill_cnt` ← `fill_cnt` − c + 16·push.
  - `bits_total` ← `bits_total` + c.
- `window_valid` = (`fill_cnt` ≥ 16). `BitStream_buffer_output` = `buf[BUF_BITS-1 -: 16]`. Both are registered-state derived.
- `flush` has priority over every other input:
  - Next cycle: `buf`, `fill_cnt`, `bits_total` and `consume_err` are all 0.
  - A word presented during the flush cycle is not accepted.
- Consume with `c`=0 is legal in any state, including an empty buffer.

## Timing

- Reset values: `BitStream_buffer_output`=0, `window_valid`=0, `bits_total`=0, `consume_err`=0. `word_ready`=1 once `reset_n` deasserts, because `fill_cnt`=0.
- Assertion of `reset_n` low clears all state immediately, including mid-stream with a full buffer.
- Latency:
  - Consume in cycle N → new window, `bits_total` and `fill_cnt` visible in cycle N+1.
  - Push in cycle N → bits visible in cycle N+1.
- Simultaneous push and consume at `fill_cnt`=`BUF_BITS`−16:
  - Both take effect.
  - `fill_cnt` stays ≤ `BUF_BITS` because c ≥ 0.
- Full buffer (`fill_cnt`=`BUF_BITS`): `word_ready`=0. A consume-only cycle reopens `word_ready` in the next cycle when the new `fill_cnt` ≤ `BUF_BITS`−16.
- Sustained throughput: 16 bits consumed per cycle with `BUF_BITS`=48 and a word pushed every cycle.
- `bits_total` wraps from 0xFFFFFF to 0 silently.

## Structure

- `BUF_BITS` default, window width (16) and `consume_len` width (5) go in the shared define file with the other bitstream constants.
- One sub-module is natural: `bitstream_barrel_shift`, a combinational left shift by 0..16 plus the word-insert alignment.
- The top holds the registers, legality check, byte-align computation and handshake.

## Test plan

- Reset, push 0xA5C3 then 0x1234 → one cycle after first push: `window_valid`=1, window=0xA5C3, `fill_cnt`=16 then 32.
- With stream A5C31234, consume 4 → window=0x5C31, `bits_total`=4. Then `byte_align` → window=0xC312, `bits_total`=8. A further `byte_align` at `bits_total`=8 → no change.
- Push three words to reach `fill_cnt`=48 → `word_ready`=0. Consume 16 with `word_valid`=1 → word not accepted. Next cycle `word_ready`=1, `fill_cnt`=32.
- `fill_cnt`=32, consume 16 and push in the same cycle for 8 consecutive cycles → `fill_cnt` stays 32, windows match the word sequence, `bits_total`=128.
- `fill_cnt`=8, `consume_len`=9 → `consume_err`=1 and stays set, window and `bits_total` unchanged. `consume_len`=17 at any fill → `consume_err`=1.
- `flush` with `word_valid`=1 at `fill_cnt`=40 → next cycle all state 0, word not accepted. Repeat with `reset_n` pulsed low mid-stream → same result asynchronously.

Source files
------------

// File: rtl/bitstream_buffer_pkg.sv
// Shared bitstream constants: window width, consume width, default buffer size.
// Also holds the byte-align distance helper used by the buffer.
package bitstream_buffer_pkg;
  localparam int BSB_BUF_BITS_DEF = 48;
  localparam int BSB_WIN_W        = 16;
  localparam int BSB_CLEN_W       = 5;
  localparam int BSB_TOTAL_W      = 24;
  localparam int BSB_MAX_CONSUME  = 16;

  // Bits remaining to the next byte boundary, given the low bits of the bit position.
  function automatic logic [2:0] align_bits(input logic [2:0] pos);
    return 3'(3'd0 - pos);
  endfunction
endpackage

// File: rtl/bitstream_buffer_if.sv
// Word-feed, consume and window signals between the NAL feeder/parsers and the buffer.
interface bitstream_buffer_if;
  import bitstream_buffer_pkg::*;

  logic                   flush;
  logic [BSB_WIN_W-1:0]   word_in;
  logic                   word_valid;
  logic                   word_ready;
  logic [BSB_CLEN_W-1:0]  consume_len;
  logic                   byte_align;
  logic [BSB_WIN_W-1:0]   BitStream_buffer_output;
  logic                   window_valid;
  logic [BSB_TOTAL_W-1:0] bits_total;
  logic                   consume_err;

  modport master (
    output flush, word_in, word_valid, consume_len, byte_align,
    input  word_ready, BitStream_buffer_output, window_valid, bits_total, consume_err
  );

  modport slave (
    input  flush, word_in, word_valid, consume_len, byte_align,
    output word_ready, BitStream_buffer_output, window_valid, bits_total, consume_err
  );
endinterface

// File: rtl/bitstream_barrel_shift.sv
// Combinational left shift of the buffer by 0..16 bits, OR-ing an incoming word
// directly behind the bits that remain valid after the shift.
module bitstream_barrel_shift
  import bitstream_buffer_pkg::*;
#(
  parameter int BUF_BITS = BSB_BUF_BITS_DEF,
  parameter int FW       = $clog2(BUF_BITS + 1)
) (
  input  logic [BUF_BITS-1:0]   data_i,
  input  logic [BSB_CLEN_W-1:0] shamt_i,
  input  logic [FW-1:0]         remain_i,
  input  logic [BSB_WIN_W-1:0]  word_i,
  input  logic                  push_i,
  output logic [BUF_BITS-1:0]   data_o
);
  localparam logic [FW-1:0] INS_TOP = FW'(BUF_BITS - BSB_WIN_W);

  logic [BUF_BITS-1:0] word_ext;
  logic [FW-1:0]       ins_sh;

  // Bits below the valid region are always zero, so a plain OR places the word.
  always_comb begin
    word_ext = push_i ? BUF_BITS'(word_i) : '0;
    ins_sh   = INS_TOP - remain_i;
    data_o   = (data_i << shamt_i) | (word_ext << ins_sh);
  end
endmodule

// File: rtl/bitstream_buffer.sv
// Bit-granular NAL payload buffer: 16-bit words in, 16-bit MSB-first window out,
// variable consume of 0..16 bits (or up to the next byte boundary) per cycle.
module bitstream_buffer
  import bitstream_buffer_pkg::*;
#(
  parameter int BUF_BITS = BSB_BUF_BITS_DEF
) (
  input  logic               clk,
  input  logic               reset_n,
  bitstream_buffer_if.slave  bus
);
  localparam int FW = $clog2(BUF_BITS + 1);
  localparam logic [FW-1:0]         PUSH_MAX  = FW'(BUF_BITS - BSB_WIN_W);
  localparam logic [FW-1:0]         WORD_BITS = FW'(BSB_WIN_W);
  localparam logic [BSB_CLEN_W-1:0] MAX_C     = BSB_CLEN_W'(BSB_MAX_CONSUME);

  logic [BUF_BITS-1:0]    data_q, data_d;
  logic [FW-1:0]          fill_cnt_q, fill_cnt_d;
  logic [BSB_TOTAL_W-1:0] total_q, total_d;
  logic                   err_q, err_d;

  logic [BSB_CLEN_W-1:0]  c_req, c_eff;
  logic                   legal, ready, push;
  logic [FW-1:0]          remain;
  logic [BUF_BITS-1:0]    shifted;

  // Ready depends only on registered fill and flush, never on the consume request.
  assign ready = (fill_cnt_q <= PUSH_MAX) && !bus.flush;
  assign push  = bus.word_valid && ready;

  always_comb begin
    c_req  = bus.byte_align ? BSB_CLEN_W'(align_bits(total_q[2:0])) : bus.consume_len;
    legal  = (c_req <= MAX_C) && (FW'(c_req) <= fill_cnt_q);
    c_eff  = legal ? c_req : '0;
    remain = fill_cnt_q - FW'(c_eff);
  end

  bitstream_barrel_shift #(.BUF_BITS(BUF_BITS), .FW(FW)) u_shift (
    .data_i   (data_q),
    .shamt_i  (c_eff),
    .remain_i (remain),
    .word_i   (bus.word_in),
    .push_i   (push),
    .data_o   (shifted)
  );

  always_comb begin
    data_d     = shifted;
    fill_cnt_d = remain + (push ? WORD_BITS : '0);
    total_d    = total_q + BSB_TOTAL_W'(c_eff);
    err_d      = err_q | ~legal;
    if (bus.flush) begin
      data_d     = '0;
      fill_cnt_d = '0;
      total_d    = '0;
      err_d      = 1'b0;
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      data_q     <= '0;
      fill_cnt_q <= '0;
      total_q    <= '0;
      err_q      <= 1'b0;
    end else begin
      data_q     <= data_d;
      fill_cnt_q <= fill_cnt_d;
      total_q    <= total_d;
      err_q      <= err_d;
    end
  end

  assign bus.word_ready              = ready;
  assign bus.BitStream_buffer_output = data_q[BUF_BITS-1 -: BSB_WIN_W];
  assign bus.window_valid            = (fill_cnt_q >= WORD_BITS);
  assign bus.bits_total              = total_q;
  assign bus.consume_err             = err_q;
endmodule
